axi_write_master: RTL
=====================

Name: axi_write_master

Overview:
- AXI4 write-channel initiator; the requesting end of the write-only slave port used by the WDT and other peripheral wrappers.
- Accepts a burst request on a simple valid/ready command port and streams beats from a valid/ready data port.
- Drives AW, then W, then collects B, and reports completion on a one-cycle done strobe.
- Sits between a CPU/DMA store path and the AXI bridge master port.

Parameters:
ID_W, 4, AWID/BID width
ADDR_W, 32, address width
DATA_W, 32, data width (WSTRB width = DATA_W/8)
LEN_W, 4, burst length field width (beats = len+1, max 16)
TIMEOUT_CYC, 1024, B-wait limit (used only with optional feature)

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
req_valid  in  1  burst request valid
req_ready  out  1  request accepted when high with req_valid
req_id  in  ID_W  transaction ID
req_addr  in  ADDR_W  start address (word aligned)
req_len  in  LEN_W  beats minus one
wd_valid  in  1  write beat valid
wd_ready  out  1  beat consumed
wd_data  in  DATA_W  beat data
wd_strb  in  DATA_W/8  beat byte strobes
done_valid  out  1  one-cycle completion strobe
done_id  out  ID_W  ID of the completed burst
done_resp  out  2  final response code
AWID_M  out  ID_W  write address ID
AWADDR_M  out  ADDR_W  write address
AWLEN_M  out  LEN_W  burst length
AWSIZE_M  out  3  constant 3'b010
AWBURST_M  out  2  constant 2'b01 (INCR)
AWVALID_M  out  1  address valid
AWREADY_M  in  1  address ready
WDATA_M  out  DATA_W  write data
WSTRB_M  out  DATA_W/8  write strobes
WLAST_M  out  1  last beat
WVALID_M  out  1  data valid
WREADY_M  in  1  data ready
BID_M  in  ID_W  response ID
BRESP_M  in  2  response code
BVALID_M  in  1  response valid
BREADY_M  out  1  response ready

Behaviour:
- Reset: FSM to IDLE; AWVALID_M, WVALID_M, BREADY_M, done_valid, wd_ready all 0; AWID/AWADDR/AWLEN registers, beat counter, done_id and done_resp all 0.
- FSM IDLE: req_ready=1. On req_valid, latch id/addr/len and go to ADDR.
- FSM ADDR: AWVALID_M=1, AW fields stable from the latched request. Hold until AWREADY_M, then go to DATA with beat counter=0. AWVALID_M is first asserted the cycle after request acceptance.
- FSM DATA: WVALID_M = wd_valid; wd_ready = WREADY_M; WDATA/WSTRB pass straight through combinationally. WLAST_M = (counter == latched len). Each handshake increments the counter. The handshake with WLAST_M moves to RESP.
- FSM RESP: BREADY_M=1. On BVALID_M, go to IDLE and pulse done_valid for one cycle (the cycle after the B handshake). done_id = latched id. done_resp = BRESP_M, or 2'b10 (SLVERR) if BID_M does not match the latched id.
- req_ready is 0 in every state except IDLE; only one outstanding burst.
- wd_ready and WVALID_M are 0 outside DATA; beats offered early are stalled, not dropped.
- len=0: single beat, WLAST_M high on the first beat.
- len=15: 16 beats, 4-bit counter reaches 15 with no wrap.
- AWREADY_M may be asserted before AWVALID_M; no dependency on it.
- BVALID_M outside RESP is ignored.
- ARESETn asserted mid-burst aborts immediately to IDLE with no done strobe.

Optional Feature:
- Macro: AXI_WM_TIMEOUT_EN.
- Defined: a counter runs in RESP. If TIMEOUT_CYC cycles elapse without BVALID_M, the FSM returns to IDLE and pulses done_valid with done_resp=2'b11 (DECERR). A late B is then ignored.
- Not defined: RESP waits indefinitely and no counter logic is present.

Decomposition:
- Shared package axi_pkg holds: fsm enum typedef (IDLE, ADDR, DATA, RESP); resp constants OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11; BURST_INCR=2'b01; SIZE_WORD=3'b010.
- No sub-module is needed; a single module is sufficient.

Test Plan:
1. Request id=3, addr=0x1001_0000, len=0, data 0x0000_0001, strb 0xF; slave ready immediately, BRESP 0 -> AWVALID one cycle after accept, WLAST on beat 1, done_valid with id=3 and resp=00.
2. len=3, beats 0xA..0xD; WREADY toggles 1,0,1,0,... -> exactly 4 W handshakes in order, WLAST only on 0xD, no beat loss.
3. AWREADY held low 5 cycles -> AWVALID/AWADDR stable for 6 cycles, req_ready=0 throughout.
4. BID=5 returned for id=3 -> done_resp=2'b10; BRESP=2'b10 with matching ID -> done_resp=2'b10.
5. ARESETn pulsed low during beat 2 of len=7 -> all outputs 0 next edge, no done_valid; new request then completes normally.
6. (AXI_WM_TIMEOUT_EN, TIMEOUT_CYC=16) BVALID never asserted -> done_valid with resp=2'b11 after 16 RESP cycles; FSM back in IDLE.

Source files
------------

// File: rtl/axi_pkg.sv
// ----------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the AXI write-channel initiator:
//   wm_state_e  - burst sequencer states (IDLE, ADDR, DATA, RESP)
//   OKAY/SLVERR/DECERR - BRESP / done_resp codes
//   BURST_INCR, SIZE_WORD - fixed AW attributes (32-bit incrementing bursts)
// ----------------------------------------------------------------------------
package axi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } wm_state_e;

    localparam logic [1:0] OKAY       = 2'b00;
    localparam logic [1:0] SLVERR     = 2'b10;
    localparam logic [1:0] DECERR     = 2'b11;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'b010;

endpackage

// File: rtl/axi_write_master.sv
// ----------------------------------------------------------------------------
// axi_write_master
// AXI4 write-channel initiator. Takes one burst request at a time on the
// req_* port, issues AW, streams the beats offered on wd_* onto W, collects
// B and reports completion with a one-cycle done_valid strobe.
//
// Ports:
//   ACLK, ARESETn           clock, asynchronous active-low reset
//   req_valid/req_ready     burst request handshake (req_id, req_addr, req_len)
//   wd_valid/wd_ready       beat handshake (wd_data, wd_strb), passed to W
//   done_valid/id/resp      completion strobe with ID and final response
//   AW*_M, W*_M, B*_M       AXI4 write address / data / response channels
//
// Optional feature (macro AXI_WM_TIMEOUT_EN): when defined, a B-wait counter
// aborts RESP after TIMEOUT_CYC cycles without BVALID_M and completes the
// burst with DECERR. When undefined, RESP waits indefinitely.
// ----------------------------------------------------------------------------
module axi_write_master
    import axi_pkg::*;
#(
    parameter int ID_W        = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ID_W-1:0]     req_id,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [LEN_W-1:0]    req_len,
    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DATA_W-1:0]   wd_data,
    input  logic [DATA_W/8-1:0] wd_strb,
    output logic                done_valid,
    output logic [ID_W-1:0]     done_id,
    output logic [1:0]          done_resp,
    output logic [ID_W-1:0]     AWID_M,
    output logic [ADDR_W-1:0]   AWADDR_M,
    output logic [LEN_W-1:0]    AWLEN_M,
    output logic [2:0]          AWSIZE_M,
    output logic [1:0]          AWBURST_M,
    output logic                AWVALID_M,
    input  logic                AWREADY_M,
    output logic [DATA_W-1:0]   WDATA_M,
    output logic [DATA_W/8-1:0] WSTRB_M,
    output logic                WLAST_M,
    output logic                WVALID_M,
    input  logic                WREADY_M,
    input  logic [ID_W-1:0]     BID_M,
    input  logic [1:0]          BRESP_M,
    input  logic                BVALID_M,
    output logic                BREADY_M
);

    wm_state_e          state, state_nxt;
    logic [LEN_W-1:0]   beat_cnt;
    logic               b_done;     // B handshake this cycle
    logic               b_timeout;  // B wait expired this cycle

`ifdef AXI_WM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;
`endif

    // Fixed attributes: every burst is INCR of 32-bit words.
    assign AWSIZE_M  = SIZE_WORD;
    assign AWBURST_M = BURST_INCR;

    // Beat payload passes straight through; only the handshake is gated.
    assign WDATA_M = wd_data;
    assign WSTRB_M = wd_strb;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        AWVALID_M = 1'b0;
        WVALID_M  = 1'b0;
        wd_ready  = 1'b0;
        WLAST_M   = 1'b0;
        BREADY_M  = 1'b0;
        b_done    = 1'b0;
        b_timeout = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ADDR;
            end
            ADDR: begin
                AWVALID_M = 1'b1;
                if (AWREADY_M) state_nxt = DATA;
            end
            DATA: begin
                // W and the beat source are joined into one handshake.
                WVALID_M = wd_valid;
                wd_ready = WREADY_M;
                WLAST_M  = (beat_cnt == AWLEN_M);
                if (wd_valid && WREADY_M && WLAST_M) state_nxt = RESP;
            end
            RESP: begin
                BREADY_M = 1'b1;
                if (BVALID_M) begin
                    b_done    = 1'b1;
                    state_nxt = IDLE;
                end
`ifdef AXI_WM_TIMEOUT_EN
                else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    b_timeout = 1'b1;
                    state_nxt = IDLE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            AWID_M     <= '0;
            AWADDR_M   <= '0;
            AWLEN_M    <= '0;
            beat_cnt   <= '0;
            done_valid <= 1'b0;
            done_id    <= '0;
            done_resp  <= OKAY;
        end else begin
            done_valid <= 1'b0;
            if (state == IDLE && req_valid) begin
                AWID_M   <= req_id;
                AWADDR_M <= req_addr;
                AWLEN_M  <= req_len;
            end
            // Hold on the last beat so a 16-beat burst never wraps the counter.
            if (state == ADDR && AWREADY_M)
                beat_cnt <= '0;
            else if (state == DATA && wd_valid && WREADY_M && !WLAST_M)
                beat_cnt <= beat_cnt + 1'b1;
            if (b_done) begin
                done_valid <= 1'b1;
                done_id    <= AWID_M;
                // A response for another ID is treated as a slave error.
                done_resp  <= (BID_M != AWID_M) ? SLVERR : BRESP_M;
            end else if (b_timeout) begin
                done_valid <= 1'b1;
                done_id    <= AWID_M;
                done_resp  <= DECERR;
            end
        end
    end

`ifdef AXI_WM_TIMEOUT_EN
    // Counts RESP cycles; zero on every RESP entry.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)            to_cnt <= '0;
        else if (state != RESP)  to_cnt <= '0;
        else                     to_cnt <= to_cnt + 1'b1;
    end
`endif

endmodule
